// File: rtl/running_high_monitor.sv
// Monitor for a stream of window maxima: peak hold, rise/fall pulses, saturating change
// counter and a hysteresis alarm FSM. Define RUNNING_HIGH_MONITOR_STICKY_EN for a latching alarm.
module running_high_monitor #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] high_in,
  input  logic             in_valid,
  input  logic             clear,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic [WIDTH-1:0] peak_out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] change_cnt,
  output logic             alarm
);

  localparam int QW = 4;
  localparam logic [QW-1:0] HOLD_Q = QW'(HOLD);

  typedef enum logic [1:0] {IDLE, PEND, ALARM} state_t;

  state_t           state, state_nxt;
  logic [QW-1:0]    qcnt, qcnt_nxt;
  logic [WIDTH-1:0] prev;
  logic             first;
  logic             accept;
  logic             is_rise, is_fall;

  assign accept  = in_valid && !clear;
  assign is_rise = !first && (high_in > prev);
  assign is_fall = !first && (high_in < prev);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_out   <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      change_cnt <= '0;
      prev       <= '0;
      first      <= 1'b1;
    end else if (clear) begin
      peak_out   <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      change_cnt <= '0;
      prev       <= '0;
      first      <= 1'b1;
    end else if (in_valid) begin
      first <= 1'b0;
      prev  <= high_in;
      rise  <= is_rise;
      fall  <= is_fall;
      if (first || (high_in > peak_out))
        peak_out <= high_in;
      if ((is_rise || is_fall) && (change_cnt != '1))
        change_cnt <= change_cnt + CNT_W'(1);
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    if (clear) begin
      state_nxt = IDLE;
      qcnt_nxt  = '0;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (high_in >= thr_hi) begin
            qcnt_nxt  = QW'(1);
            state_nxt = (HOLD_Q == QW'(1)) ? ALARM : PEND;
          end
        end
        PEND: begin
          if (high_in >= thr_hi) begin
            qcnt_nxt = qcnt + QW'(1);
            if ((qcnt + QW'(1)) == HOLD_Q)
              state_nxt = ALARM;
          end else begin
            qcnt_nxt  = '0;
            state_nxt = IDLE;
          end
        end
        ALARM: begin
`ifdef RUNNING_HIGH_MONITOR_STICKY_EN
          state_nxt = ALARM;
`else
          // Exit check comes first, so thr_lo above thr_hi still releases the alarm.
          if (high_in <= thr_lo) begin
            qcnt_nxt  = '0;
            state_nxt = IDLE;
          end
`endif
        end
        default: begin
          qcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      qcnt  <= '0;
      alarm <= 1'b0;
    end else begin
      state <= state_nxt;
      qcnt  <= qcnt_nxt;
      alarm <= (state_nxt == ALARM);
    end
  end

endmodule

// File: doc/running_high_monitor.md
RUNNING_HIGH_MONITOR -- requirements
Module: running_high_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, sample width of the window-maximum stream.
REQ-002 SHALL have parameter HOLD, default 3, consecutive qualifying samples needed to raise the alarm (legal range 1..15).
REQ-003 SHALL have parameter CNT_W, default 8, width of the change counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port high_in  input  WIDTH  window maximum from the upstream running-high stage.
REQ-007 SHALL have port in_valid  input  1  high_in is a new sample this cycle.
REQ-008 SHALL have port clear  input  1  synchronous clear of peak, counter and alarm state.
REQ-009 SHALL have port thr_hi  input  WIDTH  alarm entry threshold.
REQ-010 SHALL have port thr_lo  input  WIDTH  alarm exit threshold.
REQ-011 SHALL have port peak_out  output  WIDTH  largest accepted sample since reset/clear.
REQ-012 SHALL have port rise  output  1  one-cycle pulse: accepted sample greater than previous accepted sample.
REQ-013 SHALL have port fall  output  1  one-cycle pulse: accepted sample less than previous accepted sample.
REQ-014 SHALL have port change_cnt  output  CNT_W  count of rise plus fall events.
REQ-015 SHALL have port alarm  output  1  registered alarm flag.

Function
REQ-016 SHALL accept a sample only on cycles with in_valid=1 and clear=0; all outputs registered, 1-cycle latency from acceptance.
REQ-017 SHALL hold prev (last accepted sample) and a first-sample flag; the first accepted sample after reset/clear SHALL produce neither rise nor fall.
REQ-018 SHALL pulse rise (fall) in the cycle after acceptance when sample > prev (sample < prev); equal sample SHALL pulse neither; rise and fall never both 1.
REQ-019 SHALL drive rise=fall=0 on every cycle without an acceptance.
REQ-020 SHALL update peak_out to max(peak_out, sample) on acceptance; first accepted sample loads directly.
REQ-021 SHALL increment change_cnt on each rise or fall event, saturating at all-ones (no wrap).
REQ-022 SHALL implement alarm FSM, states IDLE, PEND, ALARM, with a qualify counter qcnt.
REQ-023 IDLE: accepted sample >= thr_hi -> qcnt=1; if HOLD=1 go ALARM, else go PEND; otherwise stay.
REQ-024 PEND: accepted sample >= thr_hi -> qcnt+1, go ALARM when qcnt+1 == HOLD; accepted sample < thr_hi -> IDLE, qcnt=0; no acceptance -> hold state and qcnt.
REQ-025 ALARM: accepted sample <= thr_lo -> IDLE (subject to REQ-031); otherwise stay.
REQ-026 SHALL drive alarm=1 exactly while FSM is in ALARM (registered, asserted cycle after the qualifying acceptance).
REQ-027 clear=1 SHALL take priority over in_valid: peak_out, change_cnt, qcnt, rise, fall, first-sample flag, FSM return to reset values next cycle; sample that cycle discarded.
REQ-028 thr_lo > thr_hi SHALL be legal: ALARM exits on first accepted sample <= thr_lo, even if it is also >= thr_hi.

Reset
REQ-029 reset=0 SHALL asynchronously force peak_out=0, rise=0, fall=0, change_cnt=0, alarm=0, FSM=IDLE, qcnt=0, prev=0, first-sample flag set.
REQ-030 Reset assertion mid-PEND or mid-ALARM SHALL abandon the sequence; after deassertion block behaves as freshly reset.

Configuration
REQ-031 SHALL support macro RUNNING_HIGH_MONITOR_STICKY_EN: when defined, ALARM exits only via clear or reset (thr_lo ignored); when undefined, ALARM exits per REQ-025.

Verification
REQ-032 Reset, then samples 3,5,5,2 valid back-to-back -> rise/fall: none,rise,none,fall; peak_out 3,5,5,5; change_cnt ends 2.
REQ-033 thr_hi=10, thr_lo=4, HOLD=3, samples 12,11,9,12,12,12 -> alarm stays 0 until cycle after sixth sample, then 1.
REQ-034 In ALARM, samples 6 then 4 -> alarm 1 after 6, 0 after 4 (macro undefined); stays 1 with RUNNING_HIGH_MONITOR_STICKY_EN defined.
REQ-035 PEND with in_valid gaps (12, idle x5, 12, 12) -> alarm 1 after third valid sample; idle cycles do not reset qcnt.
REQ-036 CNT_W=2, alternating 1,9 for 8 samples -> change_cnt saturates at 3.
REQ-037 clear and in_valid both 1 with sample 15 -> next cycle peak_out=0, alarm=0, change_cnt=0; async reset mid-ALARM -> alarm drops immediately without clock edge.
